// File: rtl/prog_clk_divider_if.sv
// Control and status bundle for the programmable multi-channel clock divider.
// The master side owns enables and the load port. The slave side (the divider)
// returns the divided clocks, the toggle ticks and the pending-load flags.
interface prog_clk_divider_if #(
    parameter int CNT_W  = 26,
    parameter int NUM_CH = 4
);
    logic [NUM_CH-1:0] ch_en;
    logic              load;
    logic [3:0]        load_ch;
    logic [CNT_W-1:0]  load_val;
    logic [NUM_CH-1:0] divided_clk;
    logic [NUM_CH-1:0] tick;
    logic [NUM_CH-1:0] pending;

    modport master (
        output ch_en,
        output load,
        output load_ch,
        output load_val,
        input  divided_clk,
        input  tick,
        input  pending
    );

    modport slave (
        input  ch_en,
        input  load,
        input  load_ch,
        input  load_val,
        output divided_clk,
        output tick,
        output pending
    );
endinterface

// File: rtl/prog_clk_divider.sv
// Programmable multi-channel clock divider.
// Each channel counts clk_in cycles up to its half-period terminal value and
// toggles its divided clock there, emitting a one-cycle tick per toggle.
// A new terminal value written while the channel runs is parked in a shadow
// register and only takes effect at the next terminal count. This means the
// half-period in progress always finishes at its old length and the output
// never glitches. A halted channel takes new values immediately.
module prog_clk_divider #(
    parameter int               CNT_W        = 26,
    parameter int               NUM_CH       = 4,
    parameter logic [CNT_W-1:0] DEFAULT_HALF = 26'd40000000
) (
    input  logic                  clk_in,
    input  logic                  rst,
    prog_clk_divider_if.slave     bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [NUM_CH-1:0] dclk_v;
    logic [NUM_CH-1:0] tick_v;
    logic [NUM_CH-1:0] pend_v;

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [3:0] CH_IDX = 4'(i);

        logic [CNT_W-1:0] cnt;
        logic [CNT_W-1:0] term;
        logic [CNT_W-1:0] shadow;
        logic             dclk;
        logic             tk;
        logic             pend;
        logic             hit;
        logic             at_term;

        // Out-of-range channel indices match no channel, so those loads
        // fall away without any special case.
        assign hit     = bus.load && (bus.load_ch == CH_IDX);
        // The counter never passes term, so all-ones is a legal terminal.
        assign at_term = (cnt == term);

        // Per-channel counter, output toggle and shadow/terminal bookkeeping.
        always_ff @(posedge clk_in or posedge rst) begin
            if (rst) begin
                cnt    <= '0;
                term   <= DEFAULT_HALF;
                shadow <= DEFAULT_HALF;
                dclk   <= 1'b0;
                tk     <= 1'b0;
                pend   <= 1'b0;
            end else if (!bus.ch_en[i]) begin
                // Halted: park at zero. A new value lands directly in term.
                // A value left pending from the running state is applied
                // now, because no half-period is in progress to protect.
                cnt  <= '0;
                dclk <= 1'b0;
                tk   <= 1'b0;
                pend <= 1'b0;
                if (hit) begin
                    term   <= bus.load_val;
                    shadow <= bus.load_val;
                end else if (pend) begin
                    term <= shadow;
                end
            end else if (at_term) begin
                // Terminal count: toggle, restart and hand over the shadow
                // value. A load arriving on this same edge is newer than any
                // parked value. It supersedes that value and waits for the
                // following terminal count.
                cnt  <= '0;
                dclk <= ~dclk;
                tk   <= 1'b1;
                if (hit) begin
                    shadow <= bus.load_val;
                    pend   <= 1'b1;
                end else if (pend) begin
                    term <= shadow;
                    pend <= 1'b0;
                end
            end else begin
                cnt <= cnt + CNT_ONE;
                tk  <= 1'b0;
                if (hit) begin
                    shadow <= bus.load_val;
                    pend   <= 1'b1;
                end
            end
        end

        assign dclk_v[i] = dclk;
        assign tick_v[i] = tk;
        assign pend_v[i] = pend;
    end

    assign bus.divided_clk = dclk_v;
    assign bus.tick        = tick_v;
    assign bus.pending     = pend_v;

endmodule

// File: doc/prog_clk_divider.md
PROG_CLK_DIVIDER -- requirements
Module: prog_clk_divider

Interface
REQ-001 Parameter CNT_W, default 26, width of every channel counter and half-period value.
REQ-002 Parameter NUM_CH, default 4, number of independent divider channels (1..16).
REQ-003 Parameter DEFAULT_HALF, default 26'd40000000, half-period terminal value loaded into every channel at reset.
REQ-004 clk_in  input  1  single source clock for all channels.
REQ-005 rst  input  1  asynchronous, active-high reset.
REQ-006 ch_en  input  NUM_CH  per-channel run enable, bit i controls channel i.
REQ-007 load  input  1  single-cycle strobe writing load_val to the channel selected by load_ch.
REQ-008 load_ch  input  4  target channel index for load.
REQ-009 load_val  input  CNT_W  new half-period terminal value.
REQ-010 divided_clk  output  NUM_CH  registered divided clock per channel.
REQ-011 tick  output  NUM_CH  registered one-clk_in-cycle pulse per channel on every divided_clk toggle.
REQ-012 pending  output  NUM_CH  bit i high while a loaded value for channel i awaits application.

Function
REQ-013 Each channel i SHALL hold an active terminal value term[i], a shadow value shadow[i], and a counter cnt[i], all CNT_W bits.
REQ-014 Enabled channel: cnt[i] != term[i] -> cnt[i] increments by 1, divided_clk[i] holds, tick[i]=0.
REQ-015 Enabled channel: cnt[i] == term[i] -> cnt[i] <= 0, divided_clk[i] inverts, tick[i]=1 for exactly that cycle.
REQ-016 Output period SHALL be 2*(term[i]+1) clk_in cycles with 50% duty; term[i]=0 gives divide-by-2 with tick high every cycle.
REQ-017 Disabled channel (ch_en[i]=0): cnt[i] <= 0, divided_clk[i] <= 0, tick[i]=0, synchronously on the next clk_in edge.
REQ-018 Re-enable: first toggle (0->1) SHALL occur term[i]+1 cycles after the first edge sampling ch_en[i]=1.
REQ-019 load with load_ch < NUM_CH SHALL write shadow[i] and set pending[i] on the next edge; load_ch >= NUM_CH SHALL be ignored with no state change.
REQ-020 Enabled channel with pending[i]=1: term[i] <= shadow[i] and pending[i] <= 0 on the edge where cnt[i]==term[i] (glitch-free, current half-period completes at old value).
REQ-021 Disabled channel: a load SHALL update term[i] directly on the next edge; pending[i] stays 0.
REQ-022 load coinciding with terminal count on the same channel: toggle uses old term, new value goes to shadow, pending[i]=1, applied at the following terminal count.
REQ-023 Second load before application SHALL overwrite shadow[i]; only the latest value is applied.
REQ-024 Channels SHALL be fully independent; a load or enable change on one channel SHALL not perturb any other channel's cnt, output or tick.
REQ-025 Counter arithmetic SHALL be unsigned CNT_W-bit; term=all-ones SHALL be legal (cnt never exceeds term, no wrap).

Reset
REQ-026 On rst=1, asynchronously: cnt=0, divided_clk=0, tick=0, pending=0, term=shadow=DEFAULT_HALF for every channel.
REQ-027 rst asserted mid-period SHALL discard any pending load; after deassertion channels resume per REQ-018 with DEFAULT_HALF.

Verification (CNT_W=8, NUM_CH=2, DEFAULT_HALF=3)
REQ-028 Reset release, ch_en=2'b11 -> both divided_clk first rise 4 cycles after enable, period 8 cycles, tick pulses every 4 cycles.
REQ-029 ch0 running, load ch0 val=1 mid half-period -> pending[0]=1 until next terminal count, then period 4 cycles; ch1 unchanged at 8.
REQ-030 ch1 disabled, load ch1 val=0, enable -> pending[1] never set, divided_clk[1] toggles every cycle, tick[1] constant 1.
REQ-031 load on exact terminal-count cycle of ch0, val=5 -> old period completes one more half-period, then half-period 6 cycles.
REQ-032 load_ch=7 val=0 -> no change to term, pending or outputs on any channel.
REQ-033 rst pulse while pending[0]=1 and divided_clk[0]=1 -> outputs 0 immediately, pending cleared, period returns to 8 cycles.
